// File: rtl/prf_writeback_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : prf_writeback_arbiter
//  Purpose  : Collects FU results into per-source holding registers and
//             round-robin arbitrates them onto the int and fp PRF write ports.
//  Revision : 1.0
// ============================================================================
module prf_writeback_arbiter #(
    parameter int NUM_SRC        = 4,
    parameter int DATA_WIDTH     = 64,
    parameter int PREG_IDX_WIDTH = 7
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [NUM_SRC-1:0]                  src_valid,
    output logic [NUM_SRC-1:0]                  src_ready,
    input  logic [NUM_SRC-1:0]                  src_is_fp,
    input  logic [NUM_SRC*PREG_IDX_WIDTH-1:0]   src_preg,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]       src_data,
    output logic                                i_rd_we,
    output logic [PREG_IDX_WIDTH-1:0]           i_rd_addr,
    output logic [DATA_WIDTH-1:0]               i_rd_data,
    output logic                                f_rd_we,
    output logic [PREG_IDX_WIDTH-1:0]           f_rd_addr,
    output logic [DATA_WIDTH-1:0]               f_rd_data,
    output logic [31:0]                         conflict_cnt
);

    localparam int c_PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]        w_hold_v;
    logic [NUM_SRC-1:0]        w_hold_fp;
    logic [PREG_IDX_WIDTH-1:0] w_hold_preg [NUM_SRC];
    logic [DATA_WIDTH-1:0]     w_hold_data [NUM_SRC];
    logic [NUM_SRC-1:0]        w_accept;
    logic [NUM_SRC-1:0]        w_int_cand, w_fp_cand;
    logic [NUM_SRC-1:0]        w_int_gnt, w_fp_gnt, w_gnt;
    logic [c_PTR_W-1:0]        w_int_sel, w_fp_sel;
    logic [c_PTR_W-1:0]        w_int_ptr_nxt, w_fp_ptr_nxt;
    logic [PREG_IDX_WIDTH-1:0] w_int_preg, w_fp_preg;
    logic [DATA_WIDTH-1:0]     w_int_data, w_fp_data;
    logic [31:0]               w_loss;
    logic [32:0]               w_cnt_sum;

    logic [c_PTR_W-1:0]        r_int_ptr, r_fp_ptr;
    logic                      r_i_we, r_f_we;
    logic [PREG_IDX_WIDTH-1:0] r_i_addr, r_f_addr;
    logic [DATA_WIDTH-1:0]     r_i_data, r_f_data;
    logic [31:0]               r_cnt;

    // (base + k) mod NUM_SRC without a divider; base + k never exceeds 2*NUM_SRC-2
    function automatic logic [c_PTR_W-1:0] rr_index(input logic [c_PTR_W-1:0] base,
                                                   input int unsigned k);
        logic [c_PTR_W:0] sum;
        sum = {1'b0, base} + (c_PTR_W+1)'(k);
        if (sum >= (c_PTR_W+1)'(NUM_SRC))
            sum = sum - (c_PTR_W+1)'(NUM_SRC);
        return sum[c_PTR_W-1:0];
    endfunction

    assign w_gnt     = w_int_gnt | w_fp_gnt;
    assign src_ready = (rst || flush) ? '0 : (~w_hold_v | w_gnt);
    assign w_accept  = src_valid & src_ready;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic                      r_v;
            logic                      r_fp;
            logic [PREG_IDX_WIDTH-1:0] r_preg;
            logic [DATA_WIDTH-1:0]     r_data;

            // Accept takes priority over grant so a drained entry refills in the same cycle
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v    <= 1'b0;
                    r_fp   <= 1'b0;
                    r_preg <= '0;
                    r_data <= '0;
                end else if (flush) begin
                    r_v <= 1'b0;
                end else if (w_accept[gi]) begin
                    r_v    <= 1'b1;
                    r_fp   <= src_is_fp[gi];
                    r_preg <= src_preg[gi*PREG_IDX_WIDTH +: PREG_IDX_WIDTH];
                    r_data <= src_data[gi*DATA_WIDTH +: DATA_WIDTH];
                end else if (w_gnt[gi]) begin
                    r_v <= 1'b0;
                end
            end

            assign w_hold_v[gi]    = r_v;
            assign w_hold_fp[gi]   = r_fp;
            assign w_hold_preg[gi] = r_preg;
            assign w_hold_data[gi] = r_data;
        end
    endgenerate

    assign w_int_cand = w_hold_v & ~w_hold_fp;
    assign w_fp_cand  = w_hold_v &  w_hold_fp;

    always_comb begin
        w_int_gnt     = '0;
        w_fp_gnt      = '0;
        w_int_sel     = '0;
        w_fp_sel      = '0;
        w_int_ptr_nxt = r_int_ptr;
        w_fp_ptr_nxt  = r_fp_ptr;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_int_sel = rr_index(r_int_ptr, k);
            if ((w_int_gnt == '0) && w_int_cand[w_int_sel]) begin
                w_int_gnt[w_int_sel] = 1'b1;
                w_int_ptr_nxt        = rr_index(w_int_sel, 1);
            end
            w_fp_sel = rr_index(r_fp_ptr, k);
            if ((w_fp_gnt == '0) && w_fp_cand[w_fp_sel]) begin
                w_fp_gnt[w_fp_sel] = 1'b1;
                w_fp_ptr_nxt       = rr_index(w_fp_sel, 1);
            end
        end
    end

    always_comb begin
        w_int_preg = '0;
        w_int_data = '0;
        w_fp_preg  = '0;
        w_fp_data  = '0;
        w_loss     = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (w_int_gnt[k]) begin
                w_int_preg = w_hold_preg[k];
                w_int_data = w_hold_data[k];
            end
            if (w_fp_gnt[k]) begin
                w_fp_preg = w_hold_preg[k];
                w_fp_data = w_hold_data[k];
            end
            if (w_hold_v[k] && !w_gnt[k])
                w_loss = w_loss + 32'd1;
        end
    end

    assign w_cnt_sum = {1'b0, r_cnt} + {1'b0, w_loss};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_int_ptr <= '0;
            r_fp_ptr  <= '0;
            r_i_we    <= 1'b0;
            r_f_we    <= 1'b0;
            r_i_addr  <= '0;
            r_f_addr  <= '0;
            r_i_data  <= '0;
            r_f_data  <= '0;
            r_cnt     <= '0;
        end else begin
            r_cnt <= w_cnt_sum[32] ? 32'hFFFF_FFFF : w_cnt_sum[31:0];
            // A flush drops this cycle's grants and leaves the pointers where they were
            if (flush) begin
                r_i_we <= 1'b0;
                r_f_we <= 1'b0;
            end else begin
                r_int_ptr <= w_int_ptr_nxt;
                r_fp_ptr  <= w_fp_ptr_nxt;
                r_i_we    <= |w_int_gnt;
                r_f_we    <= |w_fp_gnt;
                if (|w_int_gnt) begin
                    r_i_addr <= w_int_preg;
                    r_i_data <= w_int_data;
                end
                if (|w_fp_gnt) begin
                    r_f_addr <= w_fp_preg;
                    r_f_data <= w_fp_data;
                end
            end
        end
    end

    assign i_rd_we      = r_i_we;
    assign i_rd_addr    = r_i_addr;
    assign i_rd_data    = r_i_data;
    assign f_rd_we      = r_f_we;
    assign f_rd_addr    = r_f_addr;
    assign f_rd_data    = r_f_data;
    assign conflict_cnt = r_cnt;

endmodule
`default_nettype wire
